// File: rtl/mpc_sequencer_if.sv
// Handshake bundle between the IR/flags/memory side and the micro-program sequencer.
// valid/ready: no handshake here; every input is sampled each rising edge, and mem_wait is the only back-pressure.
interface mpc_sequencer_if #(
   parameter int OP_W = 6
);
   logic            run;
   logic            resume;
   logic            mem_wait;
   logic [OP_W-1:0] opcode;
   logic [15:0]     next_addr;
   logic            br_en;
   logic            zf;
   logic [15:0]     mpc_out;
   logic [1:0]      state;
   logic            halt;
   logic            illegal;
   logic [15:0]     instr_count;

   modport master (
      output run, resume, mem_wait, opcode, next_addr, br_en, zf,
      input  mpc_out, state, halt, illegal, instr_count
   );

   modport slave (
      input  run, resume, mem_wait, opcode, next_addr, br_en, zf,
      output mpc_out, state, halt, illegal, instr_count
   );
endinterface

// File: rtl/mpc_sequencer.sv
// Micro-program sequencer: owns the registered MPC, decodes opcodes into routine addresses,
// handles stalls, HLT and illegal-opcode traps, and counts decoded instructions.
module mpc_sequencer #(
   parameter logic [15:0] FETCH_ADDR  = 16'h0000,
   parameter logic [15:0] DECODE_ADDR = 16'h0001,
   parameter logic [15:0] MAP_BASE    = 16'h0400,
   parameter logic [15:0] HLT_ADDR    = 16'h07E0,
   parameter int          OP_W        = 6
) (
   input logic               clk,
   input logic               rst,
   mpc_sequencer_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   localparam logic [OP_W-1:0] OP_ILLEGAL = '1;

   state_t      r_state;
   logic [15:0] r_mpc;
   logic [15:0] r_count;
   logic        r_halt;
   logic        r_illegal;

   logic        w_at_decode;
   logic        w_op_illegal;
   logic [15:0] w_map_addr;

   assign w_at_decode  = (r_mpc == DECODE_ADDR);
   assign w_op_illegal = (bus.opcode == OP_ILLEGAL);
   // Each execute routine owns a 16-word slot above MAP_BASE.
   assign w_map_addr   = MAP_BASE + 16'({bus.opcode, 4'b0000});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_mpc     <= FETCH_ADDR;
         r_count   <= 16'h0000;
         r_halt    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_mpc <= FETCH_ADDR;
               if (bus.run) r_state <= ST_RUN;
            end
            ST_RUN: begin
               // A stall outranks everything, including a pending decode.
               if (bus.mem_wait) begin
                  r_mpc <= r_mpc;
               end else if (r_mpc == HLT_ADDR) begin
                  r_state <= ST_HALT;
                  r_halt  <= 1'b1;
               end else if (w_at_decode && w_op_illegal) begin
                  r_illegal <= 1'b1;
                  r_mpc     <= FETCH_ADDR;
               end else if (w_at_decode) begin
                  r_mpc   <= w_map_addr;
                  r_count <= r_count + 16'h0001;
               end else if (bus.br_en) begin
                  r_mpc <= bus.zf ? bus.next_addr : FETCH_ADDR;
               end else begin
                  r_mpc <= bus.next_addr;
               end
            end
            ST_HALT: begin
               r_mpc <= HLT_ADDR;
               if (bus.resume) begin
                  r_state <= ST_RUN;
                  r_halt  <= 1'b0;
                  r_mpc   <= FETCH_ADDR;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_mpc   <= FETCH_ADDR;
               r_halt  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mpc_out     = r_mpc;
   assign bus.state       = r_state;
   assign bus.halt        = r_halt;
   assign bus.illegal     = r_illegal;
   assign bus.instr_count = r_count;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Bench for mpc_sequencer: a small control-store model feeds next_addr/br_en from the MPC,
// and expected MPC sequences are queued then drained cycle by cycle.
module tb_mpc_sequencer;

   localparam int W = 16;

   logic clk;
   logic rst;

   mpc_sequencer_if #(.OP_W(6)) bus ();

   mpc_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control-store model: routine 0x00 at 0x400, LAD (0x02) at 0x420, branch routine (0x17) at 0x570.
   always_comb begin
      bus.next_addr = 16'h0000;
      bus.br_en     = 1'b0;
      case (bus.mpc_out)
         16'h0000: bus.next_addr = 16'h0001;
         16'h0400: bus.next_addr = 16'h0401;
         16'h0420: bus.next_addr = 16'h0421;
         16'h0570: begin
            bus.next_addr = 16'h0571;
            bus.br_en     = 1'b1;
         end
         default:  bus.next_addr = 16'h0000;
      endcase
   end

   logic [W-1:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // Queue length bounds the loop, so no wait here can hang.
   task automatic drain();
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         step();
         e = exp_q.pop_front();
         check("mpc", bus.mpc_out, e);
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.run      = 1'b0;
      bus.resume   = 1'b0;
      bus.mem_wait = 1'b0;
      bus.opcode   = 6'h00;
      bus.zf       = 1'b0;
      step();
      step();
      check("rst_mpc",   bus.mpc_out, 16'h0000);
      check("rst_state", 16'(bus.state), 16'h0000);
      check("rst_halt",  16'(bus.halt), 16'h0000);
      check("rst_ill",   16'(bus.illegal), 16'h0000);
      check("rst_cnt",   bus.instr_count, 16'h0000);

      // 1: simple fetch/decode/execute of opcode 0x00
      rst     = 1'b0;
      bus.run = 1'b1;
      step();
      check("run_state", 16'(bus.state), 16'h0001);
      check("run_mpc",   bus.mpc_out, 16'h0000);
      bus.run = 1'b0;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0400);
      exp_q.push_back(16'h0401);
      exp_q.push_back(16'h0000);
      drain();
      check("cnt1", bus.instr_count, 16'h0001);

      // 2: LAD with a three-cycle memory stall inside the routine
      bus.opcode = 6'h02;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0420);
      drain();
      bus.mem_wait = 1'b1;
      push_n(16'h0420, 3);
      drain();
      bus.mem_wait = 1'b0;
      exp_q.push_back(16'h0421);
      exp_q.push_back(16'h0000);
      drain();
      check("cnt2", bus.instr_count, 16'h0002);

      // 3: HLT, held for 10 cycles while run/mem_wait are ignored, then resume
      bus.opcode = 6'h3E;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h07E0);
      drain();
      check("cnt3", bus.instr_count, 16'h0003);
      check("pre_halt_state", 16'(bus.state), 16'h0001);
      step();
      check("halt_state", 16'(bus.state), 16'h0002);
      check("halt_flag",  16'(bus.halt), 16'h0001);
      check("halt_mpc",   bus.mpc_out, 16'h07E0);
      bus.run      = 1'b1;
      bus.mem_wait = 1'b1;
      push_n(16'h07E0, 9);
      drain();
      check("halt_hold", 16'(bus.halt), 16'h0001);
      bus.run      = 1'b0;
      bus.mem_wait = 1'b0;
      bus.resume   = 1'b1;
      step();
      check("resume_mpc",   bus.mpc_out, 16'h0000);
      check("resume_state", 16'(bus.state), 16'h0001);
      check("resume_halt",  16'(bus.halt), 16'h0000);
      bus.resume = 1'b0;

      // 4: illegal opcode trap
      bus.opcode = 6'h3F;
      exp_q.push_back(16'h0001);
      drain();
      check("ill_idle", 16'(bus.illegal), 16'h0000);
      exp_q.push_back(16'h0000);
      drain();
      check("ill_pulse", 16'(bus.illegal), 16'h0001);
      check("ill_cnt",   bus.instr_count, 16'h0003);
      exp_q.push_back(16'h0001);
      drain();
      check("ill_clear", 16'(bus.illegal), 16'h0000);

      // 5: conditional branch at 0x570 (opcode 0x17), taken then not taken
      bus.opcode = 6'h17;
      bus.zf     = 1'b1;
      exp_q.push_back(16'h0570);
      exp_q.push_back(16'h0571);
      exp_q.push_back(16'h0000);
      drain();
      bus.zf = 1'b0;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0570);
      exp_q.push_back(16'h0000);
      drain();
      check("cnt5", bus.instr_count, 16'h0005);

      // 6: counter wrap, then reset in the middle of a routine
      force dut.r_count = 16'hFFFF;
      #1;
      release dut.r_count;
      check("cnt_pre", bus.instr_count, 16'hFFFF);
      bus.opcode = 6'h00;
      exp_q.push_back(16'h0001);
      exp_q.push_back(16'h0400);
      drain();
      check("cnt_wrap", bus.instr_count, 16'h0000);
      exp_q.push_back(16'h0401);
      drain();
      rst = 1'b1;
      step();
      check("mid_rst_mpc",   bus.mpc_out, 16'h0000);
      check("mid_rst_state", 16'(bus.state), 16'h0000);
      check("mid_rst_cnt",   bus.instr_count, 16'h0000);
      rst = 1'b0;

      // 7: stall coinciding with decode delays the decode; resume outside HALT has no effect
      bus.run    = 1'b1;
      bus.resume = 1'b1;
      exp_q.push_back(16'h0000);
      drain();
      bus.run = 1'b0;
      exp_q.push_back(16'h0001);
      drain();
      bus.mem_wait = 1'b1;
      exp_q.push_back(16'h0001);
      drain();
      check("stall_dec_cnt", bus.instr_count, 16'h0000);
      bus.mem_wait = 1'b0;
      exp_q.push_back(16'h0400);
      drain();
      check("dec_cnt", bus.instr_count, 16'h0001);
      check("dec_state", 16'(bus.state), 16'h0001);
      bus.resume = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
